temp_sample_seq: RTL and testbench

Periodic sampling controller sitting between the temperature sensor read interface and the display processor. It schedules sensor reads on a fixed period via a req/ack handshake, enforces a response timeout, optionally averages the last four samples, and presents a stable 13-bit temperature with an update strobe to the display datapath.

---
 rtl/temp_sample_pkg.sv | 14 +
 rtl/temp_avg4.sv | 42 ++++
 rtl/temp_sample_seq.sv | 120 ++++++++++++
 tb/tb_temp_sample_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_sample_pkg.sv
// Shared types and widths for the temperature sampling controller.
package temp_sample_pkg;

    localparam int TEMP_W = 13;
    localparam int SUM_W  = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        PROC = 2'd2,
        UPD  = 2'd3
    } state_t;

endpackage

// File: rtl/temp_avg4.sv
// Four-sample moving average: history shift register plus running signed sum.
// init loads every history slot with the sample so the first result has no start-up transient.
module temp_avg4
    import temp_sample_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              init,
    input  logic [TEMP_W-1:0] sample,
    output logic [TEMP_W-1:0] avg
);

    logic [3:0][TEMP_W-1:0]   hist;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sample_ext;
    logic signed [SUM_W-1:0]  oldest_ext;
    logic signed [SUM_W-1:0]  sum_shr;

    assign sample_ext = {{(SUM_W-TEMP_W){sample[TEMP_W-1]}}, sample};
    assign oldest_ext = {{(SUM_W-TEMP_W){hist[3][TEMP_W-1]}}, hist[3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            sum  <= '0;
        end else if (load) begin
            if (init) begin
                hist <= {4{sample}};
                sum  <= {sample_ext[SUM_W-3:0], 2'b00};
            end else begin
                hist <= {hist[2:0], sample};
                sum  <= sum + sample_ext - oldest_ext;
            end
        end
    end

    // Arithmetic shift rounds toward minus infinity for negative sums.
    assign sum_shr = sum >>> 2;
    assign avg     = sum_shr[TEMP_W-1:0];

endmodule

// File: rtl/temp_sample_seq.sv
// Periodic sensor read scheduler with ack timeout and registered temperature output.
// Optional 4-sample moving average enabled by defining SAMPLE_AVG_EN.
module temp_sample_seq
    import temp_sample_pkg::*;
#(
    parameter int PERIOD  = 16000000,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rd_req,
    input  logic              rd_ack,
    input  logic [TEMP_W-1:0] rd_data,
    output logic [TEMP_W-1:0] temp_out,
    output logic              upd,
    output logic              busy,
    output logic              err,
    output logic [1:0]        state_dbg
);

    localparam int PW = $clog2(PERIOD);
    localparam int TW = $clog2(TIMEOUT);

    state_t            state;
    state_t            state_next;
    logic [PW-1:0]     count;
    logic [TW-1:0]     tcnt;
    logic [TEMP_W-1:0] cap;
    logic [TEMP_W-1:0] result;
    logic              tick;
    logic              tmo;

    assign tick      = en && (count == PW'(PERIOD - 1));
    assign tmo       = (tcnt == TW'(TIMEOUT - 1));
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (tick) state_next = REQ;
            // Ack takes priority over a timeout landing in the same cycle.
            REQ: begin
                if (rd_ack)   state_next = PROC;
                else if (tmo) state_next = IDLE;
            end
            PROC:    state_next = UPD;
            UPD:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rd_req <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            rd_req <= (state_next == REQ);
            busy   <= (state_next != IDLE);
        end
    end

    // Period counter free-runs while enabled; ticks seen outside IDLE are simply dropped.
    always_ff @(posedge clk) begin
        if (rst || !en || count == PW'(PERIOD - 1)) count <= '0;
        else                                         count <= count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
            cap  <= '0;
        end else begin
            tcnt <= (state == REQ && !rd_ack) ? tcnt + 1'b1 : '0;
            if (state == REQ && rd_ack) cap <= rd_data;
        end
    end

`ifdef SAMPLE_AVG_EN
    logic              primed;
    logic [TEMP_W-1:0] avg;

    always_ff @(posedge clk) begin
        if (rst)                primed <= 1'b0;
        else if (state == PROC) primed <= 1'b1;
    end

    temp_avg4 u_avg (
        .clk    (clk),
        .rst    (rst),
        .load   (state == PROC),
        .init   (!primed),
        .sample (cap),
        .avg    (avg)
    );

    assign result = avg;
`else
    assign result = cap;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            temp_out <= '0;
            upd      <= 1'b0;
            err      <= 1'b0;
        end else begin
            upd <= (state == UPD);
            if (state == UPD) begin
                temp_out <= result;
                err      <= 1'b0;
            end else if (state == REQ && !rd_ack && tmo) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_temp_sample_seq.sv
// Scoreboard bench for temp_sample_seq: driver pushes expected samples, monitor pops on upd.
// Build with SAMPLE_AVG_EN defined to exercise the averaging path.
module tb_temp_sample_seq;

    localparam int PERIOD  = 16;
    localparam int TIMEOUT = 20;

    logic        clk;
    logic        rst;
    logic        en;
    logic        rd_req;
    logic        rd_ack;
    logic [12:0] rd_data;
    logic [12:0] temp_out;
    logic        upd;
    logic        busy;
    logic        err;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [12:0] exp_q[$];
    int          exp_cyc_q[$];

    logic [12:0] m_hist[4];
    logic        m_primed = 1'b0;

    logic [12:0] avg_in[4] = '{13'h0100, 13'h0200, 13'h0300, 13'h0400};
`ifdef SAMPLE_AVG_EN
    logic [12:0] avg_exp[4] = '{13'h0100, 13'h0140, 13'h01C0, 13'h0280};
`else
    logic [12:0] avg_exp[4] = '{13'h0100, 13'h0200, 13'h0300, 13'h0400};
`endif

    temp_sample_seq #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rd_req    (rd_req),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .temp_out  (temp_out),
        .upd       (upd),
        .busy      (busy),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model of the displayed value for one accepted sample.
    function automatic logic [12:0] model_push(input logic [12:0] s);
        int sum;
        int q;
        logic [31:0] qv;
`ifdef SAMPLE_AVG_EN
        if (!m_primed) begin
            for (int i = 0; i < 4; i++) m_hist[i] = s;
            m_primed = 1'b1;
        end else begin
            for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = s;
        end
        sum = 0;
        for (int i = 0; i < 4; i++) sum += int'($signed(m_hist[i]));
        q  = sum >>> 2;
        qv = q;
        return qv[12:0];
`else
        return s;
`endif
    endfunction

    task automatic do_reset();
        rst    = 1'b1;
        rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        m_primed = 1'b0;
    endtask

    task automatic wait_req(output int c);
        int n;
        n = 0;
        while (rd_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, rd_req}, 32'd1);
        c = cyc;
    endtask

    // Hold off n cycles after the request was seen, then ack for one cycle.
    task automatic ack_after(input int n, input logic [12:0] data);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("req_held", {31'd0, rd_req}, 32'd1);
        end
        rd_ack  = 1'b1;
        rd_data = data;
        exp_q.push_back(model_push(data));
        exp_cyc_q.push_back(cyc + 3);
        @(negedge clk);
        rd_ack  = 1'b0;
        rd_data = 13'h0aaa;
        check("req_drop", {31'd0, rd_req}, 32'd0);
        check("busy_proc", {31'd0, busy}, 32'd1);
    endtask

    // Monitor: every upd must match the oldest expectation, two cycles after its ack.
    always @(negedge clk) begin
        if (upd === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_upd: temp_out 0x%0h with no read pending at cycle %0d", temp_out, cyc);
            end else begin
                logic [12:0] e;
                int          ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("temp_out", {19'd0, temp_out}, {19'd0, e});
                check("upd_latency", cyc, ec);
            end
        end
    end

    initial begin
        int r1, r2, hi, seen;
        logic [12:0] last;
        rst     = 1'b1;
        en      = 1'b0;
        rd_ack  = 1'b0;
        rd_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rd_req", {31'd0, rd_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_upd", {31'd0, upd}, 32'd0);
        check("rst_temp", {19'd0, temp_out}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);

        // Disabled: no request may appear.
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rd_req === 1'b1) seen = 1;
        end
        check("en_low_no_req", seen, 0);
        en = 1'b1;

        // Normal reads, period start-to-start.
        wait_req(r1);
        ack_after(3, 13'h0190);
        wait_req(r2);
        check("period", r2 - r1, PERIOD);
        ack_after(3, 13'h0050);
        repeat (2) @(negedge clk);
        last = temp_out;
        check("temp_after_2nd", {19'd0, temp_out}, {19'd0, model_last()});

        // Timeout: no ack at all.
        wait_req(r1);
        hi = 0;
        while (rd_req === 1'b1 && hi < 64) begin
            hi++;
            @(negedge clk);
        end
        check("timeout_len", hi, TIMEOUT);
        check("timeout_err", {31'd0, err}, 32'd1);
        check("timeout_temp", {19'd0, temp_out}, {19'd0, last});
        wait_req(r2);
        check("timeout_dropped_tick", r2 - r1, 2 * PERIOD);
        check("err_sticky", {31'd0, err}, 32'd1);
        ack_after(3, 13'h0123);
        repeat (2) @(negedge clk);
        check("err_cleared", {31'd0, err}, 32'd0);

        // Ack on the last timeout cycle; the request spans a dropped tick.
        wait_req(r1);
        ack_after(TIMEOUT - 1, 13'h1f00);
        repeat (2) @(negedge clk);
        check("late_ack_err", {31'd0, err}, 32'd0);
        wait_req(r2);
        check("slow_ack_gap", r2 - r1, 2 * PERIOD);
        ack_after(PERIOD + 2, 13'h00a5);
        repeat (2) @(negedge clk);

        // Averaging vectors from a clean history.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_req(r1);
            ack_after(3, avg_in[i]);
            repeat (2) @(negedge clk);
            check("avg_seq", {19'd0, temp_out}, {19'd0, avg_exp[i]});
        end
        do_reset();
        wait_req(r1);
        ack_after(3, 13'h1ff1);
        repeat (2) @(negedge clk);
        check("negative", {19'd0, temp_out}, 32'h1ff1);

        // Reset while the request is outstanding, then a stray ack.
        wait_req(r1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req", {31'd0, rd_req}, 32'd0);
        check("midrst_temp", {19'd0, temp_out}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        rst      = 1'b0;
        m_primed = 1'b0;
        @(negedge clk);
        rd_ack  = 1'b1;
        rd_data = 13'h0777;
        @(negedge clk);
        rd_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("stray_busy", {31'd0, busy}, 32'd0);
        check("stray_temp", {19'd0, temp_out}, 32'd0);
        check("stray_req", {31'd0, rd_req}, 32'd0);

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Expected display value for the most recent accepted sample (model state, not the DUT).
    function automatic logic [12:0] model_last();
        int sum;
        int q;
        logic [31:0] qv;
`ifdef SAMPLE_AVG_EN
        sum = 0;
        for (int i = 0; i < 4; i++) sum += int'($signed(m_hist[i]));
        q  = sum >>> 2;
        qv = q;
        return qv[12:0];
`else
        return 13'h0050;
`endif
    endfunction

    // Global watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded time budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
